conv_window_gen: RTL

// - Reader side of the lineBuffer delay lines: consumes a raster stream of 64-bit words (8 ch x 8 b),

---
 rtl/conv_window_gen_pkg.sv | 24 ++
 rtl/conv_window_gen_if.sv | 23 ++
 rtl/conv_window_gen_linebuf.sv | 44 ++++
 rtl/conv_window_gen.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/conv_window_gen_pkg.sv
// Shared constants and types for the 3x3 window generator: stream geometry,
// window layout and the frame-control state encoding.
package conv_window_gen_pkg;

  localparam int DATA_W    = 64;
  localparam int KERNEL    = 3;
  localparam int TAPS      = KERNEL * KERNEL;
  localparam int MAX_WIDTH = 8192;
  localparam int MAX_CG    = 64;

  // Tap (ky,kx) lives at index ky*KERNEL+kx; ky=0 is the oldest row, kx=0 the leftmost pixel.
  typedef logic [TAPS-1:0][DATA_W-1:0] window_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // A VALID-only 3x3 window needs at least three pixels in both directions.
  function automatic logic cfg_ok(input logic [15:0] width, input logic [15:0] height);
    return (width >= 16'd3) && (height >= 16'd3);
  endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Stream handshake bundle: raster words in (s_*), 3x3 windows out (m_*).
interface conv_window_gen_if;
  import conv_window_gen_pkg::*;

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  window_t           m_data;
  logic              m_last;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

endinterface

// File: rtl/conv_window_gen_linebuf.sv
// Programmable-length delay line: dout_o is the word written len_i enables ago.
// len_i=1 degenerates to a single-word delay.
module conv_window_gen_linebuf
  import conv_window_gen_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int LEN_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     ptr_q;
  logic              wrap_s;

  // Read-before-write at the same slot yields exactly len_i enables of delay.
  assign dout_o = mem_q[ptr_q];
  assign wrap_s = ({{(LEN_W-AW){1'b0}}, ptr_q} == (len_i - LEN_W'(1)));

  // Ring pointer, restarted at each frame so a new length takes effect cleanly.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      ptr_q <= '0;
    end else if (en_i) begin
      ptr_q <= wrap_s ? '0 : ptr_q + AW'(1);
    end
  end

  // Storage array; contents need no reset since emission is gated by the frame counters.
  always_ff @(posedge clk) begin
    if (en_i) begin
      mem_q[ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Builds one 3x3 VALID window per accepted raster word per channel group, using two
// row-length delay lines for the vertical taps and group-length delay lines for the horizontal ones.
module conv_window_gen
  import conv_window_gen_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [15:0]        cfg_width_i,
  input  logic [15:0]        cfg_height_i,
  input  logic [15:0]        cfg_cgroups_i,
  conv_window_gen_if.slave   bus,
  output logic               busy_o,
  output logic               done_o
);

  state_e      state_q;
  logic [15:0] w_q, h_q, cg_q;
  logic [31:0] wg_q;
  logic [15:0] r_q, c_q, g_q;
  logic        in_done_q, busy_q, done_q;
  logic        m_valid_q, m_last_q;
  window_t     m_data_q;

  logic        start_s, s_ready_s, accept_s, emit_s, last_word_s, g_wrap_s, c_wrap_s;
  logic [DATA_W-1:0] vtap1_s, vtap2_s;
  logic [KERNEL-1:0][DATA_W-1:0] row_s;
  window_t     window_s;

  assign start_s     = (state_q == ST_IDLE) & start_i;
  assign s_ready_s   = busy_q & ~in_done_q & (~m_valid_q | bus.m_ready);
  assign accept_s    = bus.s_valid & s_ready_s;
  assign g_wrap_s    = (g_q == cg_q - 16'd1);
  assign c_wrap_s    = (c_q == w_q - 16'd1);
  assign last_word_s = g_wrap_s & c_wrap_s & (r_q == h_q - 16'd1);
  assign emit_s      = accept_s & (r_q >= 16'd2) & (c_q >= 16'd2);

  conv_window_gen_linebuf #(.DEPTH(MAX_WIDTH), .LEN_W(32)) u_vbuf0 (
    .clk(clk), .rst(rst), .clear_i(start_s), .en_i(accept_s),
    .len_i(wg_q), .din_i(bus.s_data), .dout_o(vtap1_s)
  );

  conv_window_gen_linebuf #(.DEPTH(MAX_WIDTH), .LEN_W(32)) u_vbuf1 (
    .clk(clk), .rst(rst), .clear_i(start_s), .en_i(accept_s),
    .len_i(wg_q), .din_i(vtap1_s), .dout_o(vtap2_s)
  );

  // row_s[0] is the oldest row, row_s[2] the word being accepted now.
  assign row_s = {bus.s_data, vtap1_s, vtap2_s};

  for (genvar ky = 0; ky < KERNEL; ky++) begin : g_row
    logic [DATA_W-1:0] h1_s, h2_s;

    conv_window_gen_linebuf #(.DEPTH(MAX_CG), .LEN_W(16)) u_hbuf0 (
      .clk(clk), .rst(rst), .clear_i(start_s), .en_i(accept_s),
      .len_i(cg_q), .din_i(row_s[ky]), .dout_o(h1_s)
    );

    conv_window_gen_linebuf #(.DEPTH(MAX_CG), .LEN_W(16)) u_hbuf1 (
      .clk(clk), .rst(rst), .clear_i(start_s), .en_i(accept_s),
      .len_i(cg_q), .din_i(h1_s), .dout_o(h2_s)
    );

    assign window_s[ky*KERNEL+0] = h2_s;
    assign window_s[ky*KERNEL+1] = h1_s;
    assign window_s[ky*KERNEL+2] = row_s[ky];
  end

  // Frame FSM: config latch, raster position counters, busy/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      w_q       <= 16'd0;
      h_q       <= 16'd0;
      cg_q      <= 16'd0;
      wg_q      <= 32'd0;
      r_q       <= 16'd0;
      c_q       <= 16'd0;
      g_q       <= 16'd0;
      in_done_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            w_q       <= cfg_width_i;
            h_q       <= cfg_height_i;
            cg_q      <= cfg_cgroups_i;
            wg_q      <= 32'(cfg_width_i) * 32'(cfg_cgroups_i);
            r_q       <= 16'd0;
            c_q       <= 16'd0;
            g_q       <= 16'd0;
            in_done_q <= 1'b0;
            if (cfg_ok(cfg_width_i, cfg_height_i)) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (accept_s) begin
            if (g_wrap_s) begin
              g_q <= 16'd0;
              if (c_wrap_s) begin
                c_q <= 16'd0;
                r_q <= r_q + 16'd1;
              end else begin
                c_q <= c_q + 16'd1;
              end
            end else begin
              g_q <= g_q + 16'd1;
            end
            if (last_word_s) begin
              in_done_q <= 1'b1;
            end
          end
          // The final window is always produced by the final word, so its handshake closes the frame.
          if (m_valid_q && bus.m_ready && m_last_q) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Single output register; s_ready guarantees it is free whenever a new window is emitted.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
    end else if (emit_s) begin
      m_valid_q <= 1'b1;
      m_data_q  <= window_s;
      m_last_q  <= last_word_s;
    end else if (bus.m_ready) begin
      m_valid_q <= 1'b0;
    end
  end

  assign bus.s_ready = s_ready_s;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_last  = m_last_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule
